operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 30 +++
 rtl/operand_fetch_regfile.sv | 31 +++
 rtl/operand_fetch.sv | 116 +++++++++++
 tb/tb_operand_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage and its register file.
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD_A = 2'd1,
        S_RD_B = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    function automatic logic [DATA_W-1:0] shift_b(input logic [1:0] code,
                                                  input logic [DATA_W-1:0] v);
        case (code)
            SH_LSL1: return {v[DATA_W-2:0], 1'b0};
            SH_LSR1: return {1'b0, v[DATA_W-1:1]};
            SH_ASR1: return {v[DATA_W-1], v[DATA_W-1:1]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// 8 x 16 register file: one write port, two combinational read ports with
// write-first bypass so a same-cycle write is seen by the reader.
module operand_regfile
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_num_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [IDX_W-1:0]  rd_num_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_num] <= wr_data;
        end
    end

    assign rd_data_a = (wr_en && (wr_num == rd_num_a)) ? wr_data : regs[rd_num_a];
    assign rd_data_b = (wr_en && (wr_num == rd_num_b)) ? wr_data : regs[rd_num_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads A then B from the register file, applies the
// B-path shifter / immediate select and holds the pair until the ALU takes it.
//
// state  | meaning
// IDLE   | waiting for start
// RD_A   | A register loads from R[rn] on this edge
// RD_B   | B register loads from R[rm] on this edge
// HOLD   | Ain/Bin valid, waiting for out_ready
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  rn,
    input  logic [IDX_W-1:0]  rm,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] imm,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic              out_valid,
    output logic              busy
);

    state_t state, state_nxt;
    logic   accept;

    logic [IDX_W-1:0]  rn_l, rm_l;
    logic [1:0]        shift_l;
    logic              asel_l, bsel_l;
    logic [DATA_W-1:0] imm_l;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] rd_a, rd_b;

    operand_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .rd_num_a  (rn_l),
        .rd_data_a (rd_a),
        .rd_num_b  (rm_l),
        .rd_data_b (rd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RD_A;
                end
            end
            S_RD_A: state_nxt = S_RD_B;
            S_RD_B: state_nxt = S_HOLD;
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    accept    = start;
                    state_nxt = start ? S_RD_A : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Controls are captured once per transaction so later input churn is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rn_l    <= '0;
            rm_l    <= '0;
            shift_l <= SH_NONE;
            asel_l  <= 1'b0;
            bsel_l  <= 1'b0;
            imm_l   <= '0;
        end else if (accept) begin
            rn_l    <= rn;
            rm_l    <= rm;
            shift_l <= shift;
            asel_l  <= asel;
            bsel_l  <= bsel;
            imm_l   <= imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state == S_RD_A) a_q <= rd_a;
            if (state == S_RD_B) b_q <= rd_b;
        end
    end

    assign Ain = asel_l ? '0 : a_q;
    assign Bin = bsel_l ? imm_l : shift_b(shift_l, b_q);

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; inputs change and outputs
// are sampled on the falling clock edge.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n, start, asel, bsel, wr_en, out_ready;
    logic [2:0]  rn, rm, wr_num;
    logic [1:0]  shift;
    logic [15:0] imm, wr_data, Ain, Bin;
    logic        out_valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .asel      (asel),
        .bsel      (bsel),
        .imm       (imm),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .out_ready (out_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic write_reg(input logic [2:0] idx, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_num = idx; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts one transaction from IDLE, scrambles the inputs right after
    // acceptance, and stops at the first cycle with out_valid (bounded).
    task automatic issue(input logic [2:0] rn_i, input logic [2:0] rm_i,
                         input logic [1:0] sh_i, input logic a_i, input logic b_i,
                         input logic [15:0] imm_i, output int cyc);
        @(negedge clk);
        rn = rn_i; rm = rm_i; shift = sh_i; asel = a_i; bsel = b_i; imm = imm_i;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rn = ~rn_i; rm = ~rm_i; shift = ~sh_i; asel = ~a_i; bsel = ~b_i; imm = ~imm_i;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; rn = '0; rm = '0; shift = '0; asel = 1'b0;
        bsel = 1'b0; imm = '0; wr_en = 1'b0; wr_num = '0; wr_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (Ain !== 16'h0000) begin errors++; $display("FAIL reset_ain got %h want 0000", Ain); end
        checks++; if (Bin !== 16'h0000) begin errors++; $display("FAIL reset_bin got %h want 0000", Bin); end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough;
        int cyc;
        write_reg(3'd3, 16'h0005);
        write_reg(3'd5, 16'h8003);
        issue(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL pass_latency got %0d want 3", cyc); end
        checks++; if (Ain !== 16'h0005) begin errors++; $display("FAIL pass_ain got %h want 0005", Ain); end
        checks++; if (Bin !== 16'h8003) begin errors++; $display("FAIL pass_bin got %h want 8003", Bin); end
        retire;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_idle_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_shift;
        logic [1:0]  codes [3];
        logic [15:0] exp_b [3];
        int cyc;
        codes = '{2'b01, 2'b10, 2'b11};
        exp_b = '{16'h0006, 16'h4001, 16'hC001};
        for (int i = 0; i < 3; i++) begin
            issue(3'd3, 3'd5, codes[i], 1'b0, 1'b0, 16'h0000, cyc);
            checks++; if (Bin !== exp_b[i]) begin errors++; $display("FAIL shift_%b_bin got %h want %h", codes[i], Bin, exp_b[i]); end
            checks++; if (Ain !== 16'h0005) begin errors++; $display("FAIL shift_%b_ain got %h want 0005", codes[i], Ain); end
            retire;
        end
    endtask

    task automatic test_imm;
        int cyc;
        issue(3'd3, 3'd5, 2'b01, 1'b1, 1'b1, 16'hFFF0, cyc);
        checks++; if (Ain !== 16'h0000) begin errors++; $display("FAIL imm_ain got %h want 0000", Ain); end
        checks++; if (Bin !== 16'hFFF0) begin errors++; $display("FAIL imm_bin got %h want fff0", Bin); end
        retire;
    endtask

    task automatic test_collision;
        @(negedge clk);
        rn = 3'd3; rm = 3'd5; shift = 2'b00; asel = 1'b0; bsel = 1'b0; imm = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_num = 3'd5; wr_data = 16'h1234;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got %b want 1", out_valid); end
        checks++; if (Bin !== 16'h1234) begin errors++; $display("FAIL coll_bypass_bin got %h want 1234", Bin); end
        wr_data = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (Bin !== 16'h1234) begin errors++; $display("FAIL coll_hold_bin got %h want 1234", Bin); end
        checks++; if (Ain !== 16'h0005) begin errors++; $display("FAIL coll_ain got %h want 0005", Ain); end
        retire;
    endtask

    task automatic test_ignore_start;
        @(negedge clk);
        rn = 3'd3; rm = 3'd5; shift = 2'b00; asel = 1'b0; bsel = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_valid got %b want 1", out_valid); end
        retire;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_queued_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc, low;
        issue(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, cyc);
        checks++; if (Bin !== 16'hBEEF) begin errors++; $display("FAIL b2b_first_bin got %h want beef", Bin); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (Ain !== 16'h0005 || Bin !== 16'hBEEF || out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_stall%0d got %h %h %b want 0005 beef 1", i, Ain, Bin, out_valid);
            end
        end
        rn = 3'd5; rm = 3'd3; shift = 2'b11; asel = 1'b0; bsel = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        low = 0;
        while (!out_valid && low < 10) begin
            low++;
            @(negedge clk);
        end
        checks++; if (low !== 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", low); end
        checks++; if (Ain !== 16'hBEEF) begin errors++; $display("FAIL b2b_ain got %h want beef", Ain); end
        checks++; if (Bin !== 16'h0002) begin errors++; $display("FAIL b2b_bin got %h want 0002", Bin); end
        retire;
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clk);
        rn = 3'd3; rm = 3'd5; shift = 2'b00; asel = 1'b0; bsel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; wr_en = 1'b1; wr_num = 3'd2; wr_data = 16'hAAAA;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; wr_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            issue(3'(2*i), 3'(2*i+1), 2'b00, 1'b0, 1'b0, 16'h0000, cyc);
            checks++; if (Ain !== 16'h0000 || Bin !== 16'h0000) begin
                errors++; $display("FAIL rmid_regs%0d got %h %h want 0000 0000", i, Ain, Bin);
            end
            retire;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_passthrough();
        test_shift();
        test_imm();
        test_collision();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
